serial_deserializer: RTL
========================

SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 Parameter: WIDTH, 8, word length in bits (range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-004 Port: sin  input  1  serial data bit.
REQ-005 Port: sin_valid  input  1  sin qualifier; one bit is accepted per edge with sin_valid=1.
REQ-006 Port: dir  input  1  fill direction; 0 = shift left (bit enters LSB, MSB-first word), 1 = shift right (bit enters MSB, LSB-first word).
REQ-007 Port: flush  input  1  discard any partial word.
REQ-008 Port: o  output  WIDTH  assembled parallel word (holding register).
REQ-009 Port: o_valid  output  1  holding register contains an unconsumed word.
REQ-010 Port: o_ready  input  1  consumer accepts o when o_valid=1 at a rising edge.
REQ-011 Port: busy  output  1  partial word in progress (bit count nonzero).
REQ-012 Port: overrun  output  1  sticky; a completed word was dropped.
REQ-013 Port: ovr_clr  input  1  clears overrun.

Function
REQ-014 FSM states: IDLE (count=0), SHIFT (0<count<WIDTH); holding register tracked separately by o_valid.
REQ-015 IDLE -> SHIFT on an edge with sin_valid=1 (first bit); dir is latched at that edge and held for the whole word.
REQ-016 In SHIFT, each edge with sin_valid=1 shifts sin into the shift register per latched dir and increments count; sin_valid=0 holds all state.
REQ-017 On the edge accepting bit WIDTH, the full word (shift register plus that bit) is written to o, o_valid=1 from the next cycle, count returns to 0, state returns to IDLE.
REQ-018 Latency: o_valid rises exactly one cycle after the edge sampling the last bit; back-to-back words need no gap cycles.
REQ-019 Handshake: o_valid && o_ready at an edge consumes the word; o_valid falls next cycle unless a new word completes on the same edge.
REQ-020 Completion while o_valid=1 and o_ready=1 at the same edge: new word loads, o_valid stays 1, overrun unchanged.
REQ-021 Completion while o_valid=1 and o_ready=0: new word discarded, o unchanged, overrun set to 1.
REQ-022 o is stable while o_valid=1 and not consumed.
REQ-023 flush=1: count to 0, state to IDLE, shift register to 0, concurrent sin_valid bit ignored; o, o_valid, overrun unaffected.
REQ-024 ovr_clr=1 clears overrun; a drop in the same cycle takes priority (overrun stays 1).
REQ-025 busy = (state==SHIFT), registered.

Reset
REQ-026 reset=0 at an edge: state IDLE, count 0, shift register 0, o=0, o_valid=0, busy=0, overrun=0, latched dir=0.
REQ-027 Reset mid-word or with o_valid=1 discards all data; reset overrides flush, sin_valid, o_ready, ovr_clr.

Structure
REQ-028 Shared package holds the state enum (IDLE, SHIFT), DEFAULT_WIDTH=8 and the count-width function ($clog2(WIDTH+1)).
REQ-029 One sub-module, deser_bit_counter: count, increment, flush/clear, terminal-count flag at WIDTH-1 with increment.

Verification
REQ-030 reset=0 two cycles, then reset=1 -> o=0, o_valid=0, busy=0, overrun=0.
REQ-031 dir=0, bits 1,0,1,1,0,0,1,1 on consecutive cycles, o_ready=0 -> o=8'hB3, o_valid=1 one cycle after bit 8.
REQ-032 dir=1, same bit sequence -> o=8'hCD; dir toggled mid-word -> word still 8'hCD.
REQ-033 Two back-to-back words 8'hB3 then 8'h5A, o_ready=0 -> o stays 8'hB3, overrun=1; ovr_clr pulse -> overrun=0.
REQ-034 o_ready=1 held, continuous bits -> every word delivered, o_valid high continuously at completion edges, overrun=0.
REQ-035 Four bits, then flush (or reset=0) -> busy=0; next 8 bits 8'hFF -> o=8'hFF, no residue from the aborted word.

Source files
------------

// File: rtl/serial_deserializer_pkg.sv
// Shared definitions for the serial deserializer.
//   state_e        : word-assembly FSM states (IDLE = no bits held, SHIFT = partial word)
//   DEFAULT_WIDTH  : default word length in bits
//   count_width()  : width of a counter that must hold the values 0..width
package serial_deserializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_deserializer_if.sv
// Bus interface of the serial deserializer.
//   Serial side : sin, sin_valid, dir, flush
//   Word side   : o, o_valid, o_ready
//   Status      : busy, overrun, ovr_clr
// The master modport is the environment (bit producer + word consumer);
// the slave modport is the deserializer itself.
interface serial_deserializer_if
  import serial_deserializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             sin;
  logic             sin_valid;
  logic             dir;
  logic             flush;
  logic [WIDTH-1:0] o;
  logic             o_valid;
  logic             o_ready;
  logic             busy;
  logic             overrun;
  logic             ovr_clr;

  modport master (
    output sin, sin_valid, dir, flush, o_ready, ovr_clr,
    input  o, o_valid, busy, overrun
  );

  modport slave (
    input  sin, sin_valid, dir, flush, o_ready, ovr_clr,
    output o, o_valid, busy, overrun
  );

endinterface

// File: rtl/serial_deserializer_bit_counter.sv
// Bit counter for one word of the deserializer.
//   clk, reset : clock, synchronous active-low reset
//   inc_i      : one bit accepted this edge
//   clr_i      : abandon the current word (count back to 0)
//   term_o     : the bit accepted this edge completes the word
//                (count == WIDTH-1 together with inc_i); count wraps to 0
module deser_bit_counter
  import serial_deserializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic term_o
);

  localparam int CW = count_width(WIDTH);

  logic [CW-1:0] count_q, count_d;

  assign term_o = inc_i && (count_q == CW'(WIDTH - 1));

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (term_o) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel deserializer with a one-word holding register.
//   clk, reset : clock, synchronous active-low reset
//   bus        : serial_deserializer_if slave modport
//                sin/sin_valid/dir/flush in, o/o_valid/o_ready word handshake,
//                busy (partial word), overrun (sticky drop flag) / ovr_clr.
// Bits are collected in a shift register; the completing bit is merged
// combinationally so the word reaches the holding register on that same edge.
module serial_deserializer
  import serial_deserializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_deserializer_if.slave  bus
);

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             o_valid_q, o_valid_d;
  logic             overrun_q, overrun_d;

  logic             accept;
  logic             term;
  logic             eff_dir;
  logic             drop;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] shr;
  logic [WIDTH-1:0] shifted;

  // flush wins over a concurrent bit: that bit is neither counted nor shifted
  assign accept = bus.sin_valid && !bus.flush;

  deser_bit_counter #(.WIDTH(WIDTH)) u_counter (
    .clk    (clk),
    .reset  (reset),
    .inc_i  (accept),
    .clr_i  (bus.flush),
    .term_o (term)
  );

  // Both shift candidates, one bit position at a time
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
    if (gi == 0) begin : g_shl_lsb
      assign shl[gi] = bus.sin;
    end else begin : g_shl_mid
      assign shl[gi] = sh_q[gi-1];
    end
    if (gi == WIDTH - 1) begin : g_shr_msb
      assign shr[gi] = bus.sin;
    end else begin : g_shr_mid
      assign shr[gi] = sh_q[gi+1];
    end
  end

  // The first bit of a word uses the live dir; later bits use the latched copy
  assign eff_dir = (state_q == ST_IDLE) ? bus.dir : dir_q;
  assign shifted = eff_dir ? shr : shl;

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    sh_d      = sh_q;
    o_d       = o_q;
    o_valid_d = o_valid_q;
    overrun_d = overrun_q;
    drop      = 1'b0;

    if (bus.flush) begin
      state_d = ST_IDLE;
      sh_d    = '0;
    end else if (accept) begin
      if (state_q == ST_IDLE) begin
        dir_d = bus.dir;
      end
      if (term) begin
        // word leaves through the holding register; start the next one clean
        state_d = ST_IDLE;
        sh_d    = '0;
      end else begin
        state_d = ST_SHIFT;
        sh_d    = shifted;
      end
    end

    // A consume and a completion on the same edge hand over without a gap
    if (accept && term) begin
      if (!o_valid_q || bus.o_ready) begin
        o_d       = shifted;
        o_valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (o_valid_q && bus.o_ready) begin
      o_valid_d = 1'b0;
    end

    if (drop) begin
      overrun_d = 1'b1;
    end else if (bus.ovr_clr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      dir_q     <= 1'b0;
      sh_q      <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      sh_q      <= sh_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.o       = o_q;
  assign bus.o_valid = o_valid_q;
  assign bus.busy    = (state_q == ST_SHIFT);
  assign bus.overrun = overrun_q;

endmodule
